calculo_fibonacci: RTL and testbench

CALCULO_FIBONACCI -- requirements
Module: calculo_fibonacci

---
 rtl/calculo_fibonacci.sv | 120 ++++++++++++
 tb/tb_calculo_fibonacci.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/calculo_fibonacci.sv
// calculo_fibonacci
// Iterative Fibonacci engine: on a start-button rising edge it captures the
// requested index n, walks the (a, b) pair forward n times and presents
// Fib(n) mod 2^32 together with a sticky flag that says whether the true
// value no longer fits in 32 bits. Three-state controller (IDLE/CALC/DONE)
// with every output registered.
module calculo_fibonacci (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_btn,
  input  logic [31:0] n_escolhido,
  output logic [31:0] resultado,
  output logic        pronto,
  output logic        ocupado,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;

  // Button history used for rising-edge detection.
  logic        start_prev;
  logic        start_edge;

  // Iteration state: a = Fib(i), b = Fib(i+1), each modulo 2^32, with a
  // flag per term recording whether its true value has exceeded 32 bits.
  logic [31:0] n_reg;
  logic [31:0] i;
  logic [31:0] a;
  logic [31:0] b;
  logic        a_ovf;
  logic        b_ovf;

  // 33-bit sum so the carry-out of a+b is available to the overflow flag.
  logic [32:0] sum;

  assign start_edge = start_btn & ~start_prev;
  assign sum        = {1'b0, a} + {1'b0, b};

  // Register the button every cycle for edge detection.
  // NOTE: start_prev resets to 1 so a button already held when reset is
  // released looks like a level, not an edge, and cannot launch a run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_prev <= 1'b1;
    end else begin
      start_prev <= start_btn;
    end
  end

  // Controller and datapath: capture on start edge, iterate in CALC,
  // publish and hold the result in DONE.
  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values of a, b and i in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      resultado <= 32'd0;
      pronto    <= 1'b0;
      ocupado   <= 1'b0;
      overflow  <= 1'b0;
      n_reg     <= 32'd0;
      i         <= 32'd0;
      a         <= 32'd0;
      b         <= 32'd1;
      a_ovf     <= 1'b0;
      b_ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_edge) begin
            n_reg    <= n_escolhido;
            a        <= 32'd0;
            b        <= 32'd1;
            i        <= 32'd0;
            a_ovf    <= 1'b0;
            b_ovf    <= 1'b0;
            pronto   <= 1'b0;
            ocupado  <= 1'b1;
            overflow <= 1'b0;
            state    <= CALC;
          end else if (state == IDLE) begin
            // Idle keeps the last result visible but flags nothing ready.
            pronto  <= 1'b0;
            ocupado <= 1'b0;
          end
        end

        CALC: begin
          // Start edges and n_escolhido are deliberately not looked at here.
          if (i == n_reg) begin
            resultado <= a;
            overflow  <= a_ovf;
            pronto    <= 1'b1;
            ocupado   <= 1'b0;
            state     <= DONE;
          end else begin
            a     <= b;
            a_ovf <= b_ovf;
            b     <= sum[31:0];
            b_ovf <= a_ovf | b_ovf | sum[32];
            i     <= i + 32'd1;
          end
        end

        default: begin
          state   <= IDLE;
          pronto  <= 1'b0;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calculo_fibonacci.sv
// tb_calculo_fibonacci
// Directed bench for calculo_fibonacci. Expected results come from a 64-bit
// reference model and are queued when a start is driven, then popped and
// compared when the DUT raises pronto.
module tb_calculo_fibonacci;

  logic        clk;
  logic        reset;
  logic        start_btn;
  logic [31:0] n_escolhido;
  logic [31:0] resultado;
  logic        pronto;
  logic        ocupado;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          n;
    logic [31:0] res;
    logic        ovf;
  } exp_t;

  exp_t sb[$];

  calculo_fibonacci dut (
    .clk        (clk),
    .reset      (reset),
    .start_btn  (start_btn),
    .n_escolhido(n_escolhido),
    .resultado  (resultado),
    .pronto     (pronto),
    .ocupado    (ocupado),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: true Fibonacci in 64 bits, then reduced to 32 bits + overflow.
  function automatic exp_t fib_model(input int n);
    longint unsigned fa = 0;
    longint unsigned fb = 1;
    longint unsigned ft;
    exp_t e;
    for (int k = 0; k < n; k++) begin
      ft = fa + fb;
      fa = fb;
      fb = ft;
    end
    e.n   = n;
    e.res = fa[31:0];
    e.ovf = (fa[63:32] != 32'd0);
    return e;
  endfunction

  // Drive a start edge with index n and queue the expected result.
  task automatic press(input int n, input bit hold);
    @(negedge clk);
    n_escolhido = n;
    start_btn   = 1'b1;
    sb.push_back(fib_model(n));
    @(negedge clk);
    if (!hold) start_btn = 1'b0;
    check("capture_ocupado", ocupado, 1);
    check("capture_pronto", pronto, 0);
  endtask

  // Wait (bounded) for pronto, optionally disturbing inputs during CALC,
  // then compare latency, busy time and result with the scoreboard head.
  task automatic wait_done(input int disturb);
    exp_t e;
    int   cnt  = 0;
    int   busy = 0;
    e = sb.pop_front();
    busy = int'(ocupado);
    for (int t = 0; t < e.n + 20; t++) begin
      @(negedge clk);
      cnt++;
      if (pronto) break;
      busy += int'(ocupado);
      if (cnt == disturb) begin
        start_btn   = 1'b1;
        n_escolhido = 32'd5;
      end
      if (cnt == disturb + 1) start_btn = 1'b0;
    end
    check($sformatf("latency_n%0d", e.n), cnt, e.n + 1);
    check($sformatf("busy_edges_n%0d", e.n), busy, e.n + 1);
    check($sformatf("resultado_n%0d", e.n), resultado, e.res);
    check($sformatf("overflow_n%0d", e.n), overflow, e.ovf);
    check($sformatf("done_ocupado_n%0d", e.n), ocupado, 0);
  endtask

  initial begin
    reset       = 1'b1;
    start_btn   = 1'b0;
    n_escolhido = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_resultado", resultado, 0);
    check("rst_pronto", pronto, 0);
    check("rst_ocupado", ocupado, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_ocupado", ocupado, 0);

    // n = 0: single edge of latency.
    press(0, 0);
    wait_done(-1);

    // n = 10, then verify DONE holds the result.
    press(10, 0);
    wait_done(-1);
    repeat (5) @(negedge clk);
    check("hold_pronto", pronto, 1);
    check("hold_resultado", resultado, 55);

    // New start from DONE with n = 1: pronto drops at capture, result after 2.
    press(1, 0);
    wait_done(-1);

    // Overflow boundary.
    press(47, 0);
    wait_done(-1);
    press(48, 0);
    wait_done(-1);

    // Second start edge and index change during CALC are ignored.
    press(20, 0);
    wait_done(5);

    // Button held across the whole run produces exactly one start.
    press(3, 1);
    wait_done(-1);
    repeat (4) @(negedge clk);
    check("held_ocupado", ocupado, 0);
    check("held_pronto", pronto, 1);
    check("held_resultado", resultado, 2);
    start_btn = 1'b0;

    // Reset mid-CALC aborts; held button at release does not restart.
    press(30, 0);
    repeat (9) @(negedge clk);
    check("pre_reset_ocupado", ocupado, 1);
    start_btn = 1'b1;
    reset     = 1'b1;
    #1;
    check("abort_resultado", resultado, 0);
    check("abort_pronto", pronto, 0);
    check("abort_ocupado", ocupado, 0);
    check("abort_overflow", overflow, 0);
    void'(sb.pop_front());
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("held_release_ocupado", ocupado, 0);
    check("held_release_pronto", pronto, 0);
    start_btn = 1'b0;
    @(negedge clk);
    press(30, 0);
    wait_done(-1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
